// File: rtl/commit_trace_pkg.sv
// Record type and normalisation shared by the commit trace buffer and its storage.
// Define COMMIT_TRACE_MEM_EN to carry store (mem_wrt/mem_addr/mem_data) fields in each record.
package commit_trace_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [4:0]  rd;
    logic [31:0] rd_data;
`ifdef COMMIT_TRACE_MEM_EN
    logic        mem_wrt;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
`endif
  } commit_rec_t;

  localparam int unsigned REC_W = $bits(commit_rec_t);

  // Zero fields that carry no architectural meaning so the drain sees stable values.
  function automatic commit_rec_t normalise_rec(commit_rec_t rec);
    commit_rec_t n;
    n = rec;
    if (rec.rd == 5'd0) n.rd_data = '0;
`ifdef COMMIT_TRACE_MEM_EN
    if (!rec.mem_wrt) begin
      n.mem_addr = '0;
      n.mem_data = '0;
    end
`endif
    return n;
  endfunction

endpackage

// File: rtl/commit_trace_ram.sv
// DEPTH-entry record storage: one synchronous write port, one asynchronous read port.
// Record width follows COMMIT_TRACE_MEM_EN through commit_rec_t.
module commit_trace_ram
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk_i,
  input  logic                       we_i,
  input  logic [$clog2(DEPTH)-1:0]   waddr_i,
  input  commit_rec_t                wdata_i,
  input  logic [$clog2(DEPTH)-1:0]   raddr_i,
  output commit_rec_t                rdata_o
);

  commit_rec_t mem_q [DEPTH];

  // NOTE: storage has no reset; validity is tracked by the pointers and count in the parent.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_buffer.sv
// Retirement trace FIFO: never stalls the core, drops and counts records on overflow.
// Define COMMIT_TRACE_MEM_EN to capture store address/data; otherwise commit_mem_* are ignored.
module commit_trace_buffer
  import commit_trace_pkg::*;
#(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DROP_W = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     commit_valid_i,
  input  logic [31:0]              commit_pc_i,
  input  logic [31:0]              commit_instr_i,
  input  logic [4:0]               commit_rd_i,
  input  logic [31:0]              commit_rd_data_i,
  input  logic                     commit_mem_wrt_i,
  input  logic [31:0]              commit_mem_addr_i,
  input  logic [31:0]              commit_mem_data_i,
  input  logic                     clear_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output commit_rec_t              out_rec_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [DROP_W-1:0]        drop_cnt_o,
  output logic                     overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;
  logic              overflow_q, overflow_d;
  logic              full, push, pop, drop;
  commit_rec_t       raw_rec, wr_rec;

`ifdef COMMIT_TRACE_MEM_EN
  assign raw_rec = '{pc: commit_pc_i, instr: commit_instr_i, rd: commit_rd_i,
                     rd_data: commit_rd_data_i, mem_wrt: commit_mem_wrt_i,
                     mem_addr: commit_mem_addr_i, mem_data: commit_mem_data_i};
`else
  assign raw_rec = '{pc: commit_pc_i, instr: commit_instr_i, rd: commit_rd_i,
                     rd_data: commit_rd_data_i};
  logic unused_mem;
  assign unused_mem = ^{commit_mem_wrt_i, commit_mem_addr_i, commit_mem_data_i};
`endif

  assign wr_rec      = normalise_rec(raw_rec);
  assign out_valid_o = (count_q != '0);
  assign full        = (count_q == FULL_CNT);
  assign pop         = out_valid_o && out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push        = commit_valid_i && (!full || pop);
  assign drop        = commit_valid_i && full && !pop;

  // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_cnt_d = drop_cnt_q;
    overflow_d = overflow_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (clear_i) begin
      drop_cnt_d = '0;
      overflow_d = 1'b0;
    end else if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  commit_trace_ram #(.DEPTH(DEPTH)) u_ram (
    .clk_i   (clk_i),
    .we_i    (push && !rst_i),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_rec),
    .raddr_i (rd_ptr_q),
    .rdata_o (out_rec_o)
  );

  assign count_o    = count_q;
  assign drop_cnt_o = drop_cnt_q;
  assign overflow_o = overflow_q;

endmodule
